// File: rtl/pe_mem_pkg.sv
// Shared definitions for the PE scratchpad controller: geometry, op codes, FSM states.
package pe_mem_pkg;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned LEN_W  = 7;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_DRAIN = 2'b01,
      OP_CLEAR = 2'b10,
      OP_NOP   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_RD_HOLD,
      S_CLEAR,
      S_DONE
   } state_e;

   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len,
                                                input int unsigned     max_len);
      return (32'(len) > max_len) ? LEN_W'(max_len) : len;
   endfunction

endpackage

// File: rtl/pe_mem_addr_gen.sv
// Latches the command base/length and walks a wrapping scratchpad address.
module pe_mem_addr_gen
   import pe_mem_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              incr_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  off_q;
   logic [LEN_W-1:0]  off_d;

   always_comb begin
      off_d = off_q;
      if (load_i) begin
         off_d = '0;
      end else if (incr_i) begin
         off_d = off_q + LEN_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         base_q <= '0;
         len_q  <= '0;
         off_q  <= '0;
      end else begin
         if (load_i) begin
            base_q <= base_i;
            len_q  <= len_i;
         end
         off_q <= off_d;
      end
   end

   // 6-bit sum wraps modulo the scratchpad depth for free
   assign addr_o = base_q + off_q[ADDR_W-1:0];
   assign last_o = (off_q == (len_q - LEN_W'(1)));

endmodule

// File: rtl/pe_mem_ctrl.sv
// Command-driven LOAD/DRAIN/CLEAR sequencer for a synchronous-read PE scratchpad.
module pe_mem_ctrl
   import pe_mem_pkg::*;
#(
   parameter int unsigned num_bits = 8,
   parameter int unsigned depth    = DEPTH
) (
   input  logic                w_clk,
   input  logic                w_rst,
   input  logic                w_cmd_valid,
   output logic                r_cmd_ready,
   input  logic [1:0]          w_cmd_op,
   input  logic [ADDR_W-1:0]   w_cmd_base,
   input  logic [LEN_W-1:0]    w_cmd_len,
   input  logic                w_in_valid,
   output logic                r_in_ready,
   input  logic [num_bits-1:0] w_in_data,
   output logic                r_out_valid,
   input  logic                w_out_ready,
   output logic [num_bits-1:0] r_out_data,
   output logic                r_busy,
   output logic                r_done,
   output logic                r_mem_ready,
   output logic                r_mem_rw,
   output logic [ADDR_W-1:0]   r_mem_address,
   output logic [num_bits-1:0] r_mem_data_in,
   input  logic [num_bits-1:0] w_mem_data_out
);

   state_e              state_q;
   logic [num_bits-1:0] out_data_q;
   logic [ADDR_W-1:0]   addr;
   logic [LEN_W-1:0]    len_sat;
   logic                last;
   logic                accept;
   logic                in_hs;
   logic                out_hs;
   logic                step;
   op_e                 op;

   assign op      = op_e'(w_cmd_op);
   assign len_sat = sat_len(w_cmd_len, depth);
   assign accept  = w_cmd_valid && (state_q == S_IDLE) && !w_rst;
   assign in_hs   = (state_q == S_LOAD) && w_in_valid && !w_rst;
   assign out_hs  = (state_q == S_RD_HOLD) && w_out_ready && !w_rst;
   assign step    = (in_hs || out_hs) && !last;

   pe_mem_addr_gen u_addr_gen (
      .clk_i  (w_clk),
      .rst_i  (w_rst),
      .load_i (accept),
      .incr_i (step),
      .base_i (w_cmd_base),
      .len_i  (len_sat),
      .addr_o (addr),
      .last_o (last)
   );

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q    <= S_IDLE;
         out_data_q <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (len_sat == '0 || op == OP_NOP) state_q <= S_DONE;
                  else if (op == OP_LOAD)            state_q <= S_LOAD;
                  else if (op == OP_DRAIN)           state_q <= S_RD_ISSUE;
                  else                               state_q <= S_CLEAR;
               end
            end
            S_LOAD: begin
               if (in_hs && last) state_q <= S_DONE;
            end
            S_RD_ISSUE: state_q <= S_RD_WAIT;
            S_RD_WAIT: begin
               out_data_q <= w_mem_data_out;
               state_q    <= S_RD_HOLD;
            end
            S_RD_HOLD: begin
               if (out_hs) state_q <= last ? S_DONE : S_RD_ISSUE;
            end
            S_CLEAR: state_q <= S_DONE;
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Reset overrides every output immediately, including the memory clear
   always_comb begin
      r_cmd_ready   = 1'b0;
      r_in_ready    = 1'b0;
      r_out_valid   = 1'b0;
      r_busy        = 1'b0;
      r_done        = 1'b0;
      r_mem_ready   = 1'b0;
      r_mem_rw      = 1'b0;
      r_mem_address = '0;
      r_mem_data_in = '0;
      r_out_data    = '0;
      if (!w_rst) begin
         r_cmd_ready   = (state_q == S_IDLE);
         r_in_ready    = (state_q == S_LOAD);
         r_out_valid   = (state_q == S_RD_HOLD);
         r_busy        = (state_q != S_IDLE);
         r_done        = (state_q == S_DONE);
         r_mem_ready   = (state_q != S_CLEAR);
         r_mem_rw      = in_hs;
         r_mem_address = addr;
         r_mem_data_in = in_hs ? w_in_data : '0;
         r_out_data    = out_data_q;
      end
   end

endmodule
